// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and helpers for the display arbiter
package disp_pkg;

  localparam int DIGIT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OPEN
  } state_t;

  // True when any 4-bit digit of the packed value is outside 0..9.
  function automatic logic bcd_bad(input logic [DIGIT_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGIT_W / 4; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// rtl/disp_arbiter_rr_pick.sv - combinational round-robin winner search
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [NREQ-1:0] cand;

  assign cand = req & ~mask;

  // Search starts just after ptr and wraps, so ptr itself is tried last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!valid && cand[(int'(ptr) + i) % NREQ]) begin
        winner[(int'(ptr) + i) % NREQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - round-robin display arbiter with minimum hold time
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int          NREQ       = 3,
  parameter int          HOLD_TICKS = 27_000_000,
  parameter logic [15:0] IDLE_VAL   = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [DIGIT_W*NREQ-1:0] data,
  output logic [NREQ-1:0]         gnt,
  output logic [DIGIT_W-1:0]      digito,
  output logic                    busy,
  output logic                    bcd_err
);

  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_TICKS - 1);

  state_t            state, state_n;
  logic [CW-1:0]     hold_cnt, cnt_n;
  logic [PW-1:0]     ptr, ptr_n, win_idx;
  logic [NREQ-1:0]   gnt_n, winner;
  logic              win_valid, take;
  logic [DIGIT_W-1:0] sel, digito_n;
  logic              bcd_err_n, busy_n;

  // Masking the current grant only matters for the OPEN switch search;
  // on release the granted req is already low.
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mask   (gnt),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      hold_cnt <= '0;
      ptr      <= PW'(NREQ - 1);
      digito   <= IDLE_VAL;
      busy     <= 1'b0;
      bcd_err  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      hold_cnt <= cnt_n;
      ptr      <= ptr_n;
      digito   <= digito_n;
      busy     <= busy_n;
      bcd_err  <= bcd_err_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = hold_cnt;
    ptr_n   = ptr;
    take    = 1'b0;
    case (state)
      IDLE: take = win_valid;
      HOLD, OPEN: begin
        // Release wins over expiry and switch in the same cycle.
        if ((gnt & req) == '0) begin
          if (win_valid) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
          end
        end else if (state == HOLD) begin
          if (hold_cnt == '0) state_n = OPEN;
          else                cnt_n   = hold_cnt - 1'b1;
        end else begin
          take = win_valid;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
    if (take) begin
      state_n = HOLD;
      gnt_n   = winner;
      cnt_n   = CNT_LOAD;
      ptr_n   = win_idx;
    end
  end

  // Outputs follow the next-state grant so they line up with gnt.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_n[i]) sel = sel | data[DIGIT_W*i +: DIGIT_W];
    end
    busy_n = |gnt_n;
    if (gnt_n == '0) begin
      digito_n  = IDLE_VAL;
      bcd_err_n = 1'b0;
    end else begin
      digito_n  = sel;
      bcd_err_n = bcd_bad(sel);
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - directed self-checking bench for disp_arbiter
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [47:0] data = '0;
  logic [2:0]  gnt;
  logic [15:0] digito;
  logic        busy;
  logic        bcd_err;

  int checks = 0;
  int failures = 0;

  disp_arbiter #(.NREQ(3), .HOLD_TICKS(4), .IDLE_VAL(16'hFFFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .digito  (digito),
    .busy    (busy),
    .bcd_err (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b000;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (digito !== 16'hFFFF) begin failures++; $display("FAIL reset_digito got=%h exp=ffff", digito); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bcd_err !== 1'b0) begin failures++; $display("FAIL reset_bcd_err got=%b exp=0", bcd_err); end
  endtask

  task automatic test_single();
    do_reset();
    data[15:0] = 16'h1234;
    req = 3'b001;
    step();
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL single_gnt got=%b exp=001", gnt); end
    checks++; if (digito !== 16'h1234) begin failures++; $display("FAIL single_digito got=%h exp=1234", digito); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL single_hold k=%0d got=%b exp=001", k, gnt); end
    end
    data[15:0] = 16'h5678;
    step();
    checks++; if (digito !== 16'h5678) begin failures++; $display("FAIL single_live got=%h exp=5678", digito); end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL single_idle_gnt got=%b exp=000", gnt); end
    checks++; if (digito !== 16'hFFFF) begin failures++; $display("FAIL single_idle_digito got=%h exp=ffff", digito); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_alternate();
    logic [2:0]  exp_g;
    logic [15:0] exp_d;
    do_reset();
    data[15:0]  = 16'h1111;
    data[31:16] = 16'h2222;
    req = 3'b011;
    step();
    for (int k = 0; k < 15; k++) begin
      exp_g = ((k / 5) % 2 == 0) ? 3'b001 : 3'b010;
      exp_d = ((k / 5) % 2 == 0) ? 16'h1111 : 16'h2222;
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, gnt, exp_g); end
      checks++; if (digito !== exp_d) begin failures++; $display("FAIL alt_digito k=%0d got=%h exp=%h", k, digito, exp_d); end
      step();
    end
  endtask

  task automatic test_rr_wrap();
    logic [2:0] exp_g;
    logic [2:0] one;
    do_reset();
    one = 3'b001;
    req = 3'b111;
    step();
    for (int k = 0; k < 16; k++) begin
      exp_g = one << ((k / 5) % 3);
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, exp_g); end
      step();
    end
  endtask

  task automatic test_release();
    do_reset();
    data[15:0]  = 16'h0101;
    data[47:32] = 16'h0303;
    req = 3'b101;
    step();
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rel_first got=%b exp=001", gnt); end
    step();
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rel_hold got=%b exp=001", gnt); end
    req = 3'b100;
    step();
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL rel_handoff got=%b exp=100", gnt); end
    checks++; if (digito !== 16'h0303) begin failures++; $display("FAIL rel_digito got=%h exp=0303", digito); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rel_busy got=%b exp=1", busy); end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL rel_idle got=%b exp=000", gnt); end
    checks++; if (digito !== 16'hFFFF) begin failures++; $display("FAIL rel_idle_digito got=%h exp=ffff", digito); end
  endtask

  task automatic test_bcd_and_abort();
    do_reset();
    data[31:16] = 16'h12A4;
    req = 3'b010;
    step();
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL bcd_gnt got=%b exp=010", gnt); end
    checks++; if (digito !== 16'h12A4) begin failures++; $display("FAIL bcd_digito got=%h exp=12a4", digito); end
    checks++; if (bcd_err !== 1'b1) begin failures++; $display("FAIL bcd_err_set got=%b exp=1", bcd_err); end
    data[31:16] = 16'h0999;
    step();
    checks++; if (bcd_err !== 1'b0) begin failures++; $display("FAIL bcd_err_clr got=%b exp=0", bcd_err); end
    checks++; if (digito !== 16'h0999) begin failures++; $display("FAIL bcd_digito2 got=%h exp=0999", digito); end
    data[31:16] = 16'h12A4;
    step();
    rst = 1'b1;
    step();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL abort_gnt got=%b exp=000", gnt); end
    checks++; if (digito !== 16'hFFFF) begin failures++; $display("FAIL abort_digito got=%h exp=ffff", digito); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (bcd_err !== 1'b0) begin failures++; $display("FAIL abort_bcd_err got=%b exp=0", bcd_err); end
    rst = 1'b0;
    step();
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL resume_gnt got=%b exp=010", gnt); end
    checks++; if (bcd_err !== 1'b1) begin failures++; $display("FAIL resume_bcd_err got=%b exp=1", bcd_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_rr_wrap();
    test_release();
    test_bcd_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
